// File: rtl/pri_enc_scan.sv
// Captures a request vector and emits one beat per set bit, lowest index first.
// Define PRI_ENC_SCAN_CNT_EN to add out_cnt, the popcount of the captured vector.
module pri_enc_scan #(
    parameter int WIDTH = 8,
    parameter int IDXW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_vec,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDXW-1:0]  out_idx,
    output logic             out_last,
    output logic             out_none,
    output logic             busy
`ifdef PRI_ENC_SCAN_CNT_EN
    ,
    output logic [IDXW:0]    out_cnt
`endif
);

    typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

    state_t           state;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] rest;
    logic [IDXW-1:0]  idx_c;
    logic             scan;

    assign scan = (state == SCAN);

    // Dropping the lowest set bit also tells us whether at most one bit remains.
    assign rest = res & (res - WIDTH'(1));

    always_comb begin
        idx_c = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (res[i]) idx_c = IDXW'(i);
        end
    end

    assign in_ready  = !scan;
    assign busy      = scan;
    assign out_valid = scan;
    assign out_idx   = scan ? idx_c : '0;
    assign out_last  = scan && (rest == '0);
    // Residual is only zero during SCAN when the captured vector was zero.
    assign out_none  = scan && (res == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            res   <= '0;
        end else if (flush) begin
            state <= IDLE;
            res   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        res   <= in_vec;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (out_ready) begin
                        res <= rest;
                        if (rest == '0) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PRI_ENC_SCAN_CNT_EN
    logic [IDXW:0] pop;

    always_comb begin
        pop = '0;
        for (int i = 0; i < WIDTH; i++) pop = pop + (IDXW+1)'(in_vec[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                   out_cnt <= '0;
        else if (in_ready && in_valid && !flush) out_cnt <= pop;
    end
`endif

endmodule
